// File: rtl/sar_search.sv
// ---------------------------------------------------------------------------
// sar_search : successive-approximation search of a comparator's A operand
// Rev 1.0    : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sar_search #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         agtb,
  input  logic         altb,
  input  logic         aeqb,
  output logic [W-1:0] guess,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         found,
  output logic         err
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TEST   = 2'd1;
  localparam logic [1:0] S_VERIFY = 2'd2;

  localparam logic [KW-1:0] c_KMAX = KW'(W - 1);
  localparam logic [W-1:0]  c_ONE  = W'(1);
  localparam logic [W-1:0]  c_MSB  = c_ONE << (W - 1);

  logic [1:0]    r_state;
  logic [KW-1:0] r_k;
  logic [W-1:0]  r_guess;
  logic [W-1:0]  r_result;
  logic          r_busy;
  logic          r_done;
  logic          r_found;
  logic          r_err;

  logic          w_legal;
  logic [W-1:0]  w_bit;
  logic [W-1:0]  w_tested;
  logic [W-1:0]  w_next;

  // Exactly one flag high is the only legal comparator answer.
  assign w_legal = ({agtb, altb, aeqb} == 3'b100) ||
                   ({agtb, altb, aeqb} == 3'b010) ||
                   ({agtb, altb, aeqb} == 3'b001);

  // Resolve bit k from the flags, then tentatively set the next lower bit.
  always_comb begin
    w_bit    = c_ONE << r_k;
    w_tested = altb ? (r_guess & ~w_bit) : r_guess;
    w_next   = (r_k != '0) ? (w_tested | (w_bit >> 1)) : w_tested;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_k      <= c_KMAX;
      r_guess  <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_found  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_guess <= c_MSB;
            r_k     <= c_KMAX;
            r_busy  <= 1'b1;
            r_found <= 1'b0;
            r_err   <= 1'b0;
            r_state <= S_TEST;
          end
        end
        S_TEST: begin
          if (!w_legal) begin
            r_err    <= 1'b1;
            r_found  <= 1'b0;
            r_result <= r_guess;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (aeqb) begin
            r_found  <= 1'b1;
            r_result <= r_guess;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_guess <= w_next;
            if (r_k != '0) begin
              r_k <= r_k - KW'(1);
            end else begin
              r_state <= S_VERIFY;
            end
          end
        end
        S_VERIFY: begin
          r_err    <= !w_legal;
          r_found  <= w_legal && aeqb;
          r_result <= r_guess;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign guess  = r_guess;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign found  = r_found;
  assign err    = r_err;

endmodule

`default_nettype wire
